window_scan_ctrl: RTL and testbench

- Sequencer for the 3x3 window-fetch image RAM.
- Raster-scans every valid 3x3 window of an IMG_SIZE x IMG_SIZE frame and drives the RAM's top-left base address.
- Presents each window to the downstream convolution filter with a valid/ready handshake.
- Supplies the output-image write address and frame-level start/busy/done control.

---
 rtl/img_pkg.sv | 15 +
 rtl/scan_counter.sv | 48 ++++
 rtl/window_scan_ctrl.sv | 90 +++++++++
 tb/tb_window_scan_ctrl.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/img_pkg.sv
// Shared constants and scan-state encoding for the 3x3 window-fetch sequencer.
package img_pkg;

  localparam int IMG_SIZE = 256;
  localparam int ADDR_W   = 16;
  localparam int WIN_LAST = IMG_SIZE - 3;
  localparam int OUT_SIZE = IMG_SIZE - 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } scan_state_e;

endpackage

// File: rtl/scan_counter.sv
// Window row/column counters with incremental RAM and output-image addresses.
module scan_counter #(
  parameter int IMG_SIZE = img_pkg::IMG_SIZE,
  parameter int ADDR_W   = img_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              advance,
  output logic [ADDR_W-1:0] imAddr,
  output logic [ADDR_W-1:0] outAddr,
  output logic [ADDR_W-1:0] winRow,
  output logic [ADDR_W-1:0] winCol,
  output logic              lastWin
);

  localparam logic [ADDR_W-1:0] WinLast = ADDR_W'(IMG_SIZE - 3);
  localparam logic [ADDR_W-1:0] One     = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] Three   = ADDR_W'(3);

  logic colLast;
  logic rowLast;

  assign colLast = (winCol == WinLast);
  assign rowLast = (winRow == WinLast);
  assign lastWin = colLast & rowLast;

  // The final window is not advanced past, so the counters keep its coordinates.
  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      imAddr  <= '0;
      outAddr <= '0;
      winRow  <= '0;
      winCol  <= '0;
    end else if (advance && !lastWin) begin
      outAddr <= outAddr + One;
      if (colLast) begin
        winCol <= '0;
        winRow <= winRow + One;
        imAddr <= imAddr + Three;
      end else begin
        winCol <= winCol + One;
        imAddr <= imAddr + One;
      end
    end
  end

endmodule

// File: rtl/window_scan_ctrl.sv
// Frame-level FSM and valid/ready handshake for the 3x3 window scan.
// Optional AUTO_RESTART_EN: DONE restarts the scan directly for continuous streaming.
module window_scan_ctrl #(
  parameter int IMG_SIZE = img_pkg::IMG_SIZE,
  parameter int ADDR_W   = img_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  output logic [ADDR_W-1:0] im_addr,
  output logic              win_valid,
  input  logic              win_ready,
  output logic [ADDR_W-1:0] out_addr,
  output logic [ADDR_W-1:0] win_row,
  output logic [ADDR_W-1:0] win_col,
  output logic              busy,
  output logic              done
);

  import img_pkg::*;

  scan_state_e state;
  scan_state_e stateNext;
  logic        fire;
  logic        clearCnt;
  logic        lastWin;

  // Abort wins over a simultaneous handshake: that window is not accepted.
  assign fire = win_valid & win_ready & ~abort;

  scan_counter #(
    .IMG_SIZE (IMG_SIZE),
    .ADDR_W   (ADDR_W)
  ) uCounter (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (clearCnt),
    .advance (fire),
    .imAddr  (im_addr),
    .outAddr (out_addr),
    .winRow  (win_row),
    .winCol  (win_col),
    .lastWin (lastWin)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  always_comb begin
    stateNext = state;
    clearCnt  = 1'b0;
    win_valid = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          stateNext = SCAN;
          clearCnt  = 1'b1;
        end
      end
      SCAN: begin
        win_valid = 1'b1;
        busy      = 1'b1;
        if (abort) begin
          stateNext = IDLE;
        end else if (fire && lastWin) begin
          stateNext = DONE;
        end
      end
      DONE: begin
        done = 1'b1;
`ifdef AUTO_RESTART_EN
        stateNext = SCAN;
        clearCnt  = 1'b1;
`else
        stateNext = IDLE;
`endif
      end
      default: stateNext = IDLE;
    endcase
  end

endmodule

// File: tb/tb_window_scan_ctrl.sv
// Directed/randomized bench for window_scan_ctrl at IMG_SIZE=8 with a window-index reference model.
module tb_window_scan_ctrl;

  localparam int IMG  = 8;
  localparam int AW   = 16;
  localparam int OUTW = IMG - 2;
  localparam int NWIN = OUTW * OUTW;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic          abort;
  logic [AW-1:0] im_addr;
  logic          win_valid;
  logic          win_ready;
  logic [AW-1:0] out_addr;
  logic [AW-1:0] win_row;
  logic [AW-1:0] win_col;
  logic          busy;
  logic          done;

  int checks = 0;
  int errors = 0;

  window_scan_ctrl #(.IMG_SIZE(IMG), .ADDR_W(AW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .abort     (abort),
    .im_addr   (im_addr),
    .win_valid (win_valid),
    .win_ready (win_ready),
    .out_addr  (out_addr),
    .win_row   (win_row),
    .win_col   (win_col),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  function automatic int expRow(input int k);
    return k / OUTW;
  endfunction

  function automatic int expCol(input int k);
    return k % OUTW;
  endfunction

  function automatic int expIm(input int k);
    return expRow(k) * IMG + expCol(k);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkIdle(input string tag);
    check({tag, "_valid"}, 32'(win_valid), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
  endtask

  task automatic checkWin(input string tag, input int k);
    check({tag, "_valid"}, 32'(win_valid), 32'd1);
    check({tag, "_busy"}, 32'(busy), 32'd1);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_im"}, 32'(im_addr), 32'(expIm(k)));
    check({tag, "_out"}, 32'(out_addr), 32'(k));
    check({tag, "_row"}, 32'(win_row), 32'(expRow(k)));
    check({tag, "_col"}, 32'(win_col), 32'(expCol(k)));
  endtask

  // Scans one whole frame starting from the current SCAN cycle; returns on the done cycle.
  task automatic runFrame(input string tag, input int pct);
    int k = 0;
    int cyc = 0;
    while (k < NWIN && cyc < 4000) begin
      win_ready = ($urandom_range(99) < 32'(pct));
      checkWin(tag, k);
      if (k == 18) begin
        check({tag, "_wrap_im"}, 32'(im_addr), 32'd24);
        check({tag, "_wrap_row"}, 32'(win_row), 32'd3);
        check({tag, "_wrap_col"}, 32'(win_col), 32'd0);
      end
      tick();
      if (win_ready) k++;
      cyc++;
    end
    win_ready = 1'b0;
    check({tag, "_fires"}, 32'(k), 32'(NWIN));
    check({tag, "_done_pulse"}, 32'(done), 32'd1);
    check({tag, "_done_busy"}, 32'(busy), 32'd0);
    check({tag, "_done_valid"}, 32'(win_valid), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b1;
    abort = 1'b0;
    win_ready = 1'b0;

    for (int i = 0; i < 3; i++) begin
      tick();
      checkIdle("rst");
      check("rst_im", 32'(im_addr), 32'd0);
      check("rst_out", 32'(out_addr), 32'd0);
    end
    rst_n = 1'b1;
    start = 1'b0;
    tick();
    checkIdle("idle");
    check("idle_row", 32'(win_row), 32'd0);
    check("idle_col", 32'(win_col), 32'd0);

    start = 1'b1;
    tick();
    start = 1'b0;
    runFrame("full", 100);
    tick();
`ifdef AUTO_RESTART_EN
    runFrame("frame2", 30);
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    checkIdle("auto_abort");
    tick();
    checkIdle("auto_abort_hold");
`else
    checkIdle("post_done");
    check("retain_im", 32'(im_addr), 32'(expIm(NWIN - 1)));
    check("retain_out", 32'(out_addr), 32'(NWIN - 1));
    start = 1'b1;
    tick();
    start = 1'b0;
    runFrame("bp", 30);
    tick();
    checkIdle("bp_post");
`endif

    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 10; k++) begin
      win_ready = 1'b1;
      checkWin("pre_abort", k);
      tick();
    end
    check("abort_at_out", 32'(out_addr), 32'd10);
    abort = 1'b1;
    win_ready = 1'b1;
    tick();
    abort = 1'b0;
    win_ready = 1'b0;
    checkIdle("abort");
    tick();
    checkIdle("abort_hold");
    start = 1'b1;
    tick();
    start = 1'b0;
    checkWin("restart", 0);

    win_ready = 1'b1;
    tick();
    tick();
    checkWin("pre_rst", 2);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    win_ready = 1'b0;
    checkIdle("midrst");
    check("midrst_im", 32'(im_addr), 32'd0);
    tick();
    checkIdle("midrst_hold");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
